uart_rx_param: RTL and testbench

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 97 +++++++++
 tb/tb_uart_rx_param.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampling UART receiver with optional parity, a single holding register and a sticky overrun flag
module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 RxD,
   input  logic                 Baud,
   input  logic                 rd_rx,
   output logic [DATA_BITS-1:0] RxD_data,
   output logic                 RDA,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun
);
   localparam int CW = $clog2(OVERSAMPLE) + 1;
   localparam int BW = $clog2(DATA_BITS + 1);
   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
   state_t               state, state_nx;
   logic                 rx_s1, rx_s2, rx_prev;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        bits;
   logic [DATA_BITS-1:0] sh;
   logic                 par_flag, hit, fall, done, last_bit;

   // two-flop synchronizer plus one delayed copy so a start needs a real high-to-low transition
   always_ff @(posedge clk or posedge rst)
      if (rst) {rx_s1, rx_s2, rx_prev} <= 3'b111;
      else     {rx_s1, rx_s2, rx_prev} <= {RxD, rx_s1, rx_s2};

   // state register
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else     state <= state_nx;

   // next-state logic; the parity state exists only when parity is enabled
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = fall ? START : IDLE;
         START:   state_nx = hit ? (rx_s2 ? IDLE : DATA) : START;
         DATA:    state_nx = (hit && last_bit) ? ((PARITY != 0) ? PAR : STOP) : DATA;
         PAR:     state_nx = hit ? STOP : PAR;
         STOP:    state_nx = hit ? IDLE : STOP;
         default: state_nx = IDLE;
      endcase
   end

   // sample strobe lands mid-bit: half a bit after the start edge, then every full bit
   always_comb begin
      fall     = rx_prev & ~rx_s2;
      hit      = Baud && (cnt + 1'b1 == ((state == START) ? CW'(OVERSAMPLE / 2) : CW'(OVERSAMPLE)));
      last_bit = bits == BW'(DATA_BITS - 1);
      done     = (state == STOP) && hit;
   end

   // tick counter, bit counter, shift register and parity check
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt      <= '0;
         bits     <= '0;
         sh       <= '0;
         par_flag <= 1'b0;
      end else begin
         cnt <= (state == IDLE || hit) ? '0 : cnt + CW'(Baud);
         if (state == IDLE) begin
            bits     <= '0;
            par_flag <= 1'b0;
         end
         if (state == DATA && hit) begin
            sh   <= {rx_s2, sh[DATA_BITS-1:1]};
            bits <= bits + 1'b1;
         end
         if (state == PAR && hit) par_flag <= ^{sh, rx_s2, 1'(PARITY == 2)};
      end

   // holding register: a completed frame loads when the register is free or being read this clk, otherwise it is dropped
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         RxD_data   <= '0;
         RDA        <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         if (done && (!RDA || rd_rx)) begin
            RxD_data   <= sh;
            frame_err  <= ~rx_s2;
            parity_err <= (PARITY != 0) && par_flag;
            RDA        <= 1'b1;
         end else if (rd_rx && RDA) RDA <= 1'b0;
         if (done && RDA && !rd_rx) overrun <= 1'b1;
         else if (rd_rx && RDA && !done) overrun <= 1'b0;
      end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench driving three receiver configurations with directed frames
module tb_uart_rx_param;
   typedef struct packed {logic [8:0] data; logic fe; logic pe;} exp_t;
   logic       clk = 0, rst = 1, bd = 0;
   logic       rx[3] = '{1'b1, 1'b1, 1'b1};
   logic       rd[3] = '{1'b0, 1'b0, 1'b0};
   logic       rda[3], fe[3], pe[3], ov[3];
   logic [7:0] d0, d1;
   logic [4:0] d2;
   logic [8:0] dv[3];
   exp_t       q[3][$];
   int         compared = 0, mismatched = 0;

   assign dv[0] = 9'(d0);
   assign dv[1] = 9'(d1);
   assign dv[2] = 9'(d2);

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      #1 bd = ~bd;
   end

   uart_rx_param u0 (.clk(clk), .rst(rst), .RxD(rx[0]), .Baud(bd), .rd_rx(rd[0]), .RxD_data(d0),
                     .RDA(rda[0]), .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ov[0]));
   uart_rx_param #(.PARITY(1)) u1 (.clk(clk), .rst(rst), .RxD(rx[1]), .Baud(bd), .rd_rx(rd[1]), .RxD_data(d1),
                     .RDA(rda[1]), .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ov[1]));
   uart_rx_param #(.DATA_BITS(5), .OVERSAMPLE(8), .PARITY(2)) u2 (.clk(clk), .rst(rst), .RxD(rx[2]), .Baud(bd),
                     .rd_rx(rd[2]), .RxD_data(d2), .RDA(rda[2]), .frame_err(fe[2]), .parity_err(pe[2]), .overrun(ov[2]));

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   function automatic void push(int k, logic [8:0] data, logic f, logic p);
      q[k].push_back(exp_t'({data, f, p}));
   endfunction

   task automatic hold(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // frame = start, data LSB first, optional parity bit (pbit<0 means none), stop, then one idle bit
   task automatic send(int k, logic [8:0] data, int nb, int os, int pbit, logic stop);
      int bt = os * 2;
      rx[k] = 1'b0;
      hold(bt);
      for (int i = 0; i < nb; i++) begin
         rx[k] = data[i];
         hold(bt);
      end
      if (pbit >= 0) begin
         rx[k] = pbit[0];
         hold(bt);
      end
      rx[k] = stop;
      hold(bt);
      rx[k] = 1'b1;
      hold(bt);
   endtask

   task automatic drain(int k);
      int t = 0;
      while (q[k].size() != 0 && t < 4000) begin
         @(negedge clk);
         t++;
      end
      check($sformatf("u%0d words delivered", k), q[k].size(), 0);
   endtask

   task automatic rd_word(int k);
      @(posedge clk);
      #1 rd[k] = 1'b1;
      @(posedge clk);
      #1 rd[k] = 1'b0;
      check($sformatf("u%0d RDA after rd_rx", k), rda[k], 0);
   endtask

   task automatic monitor();
      logic p[3];
      exp_t e;
      p = '{1'b0, 1'b0, 1'b0};
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (rda[k] && !p[k]) begin
               check($sformatf("u%0d word expected", k), q[k].size() != 0, 1);
               if (q[k].size() != 0) begin
                  e = q[k].pop_front();
                  check($sformatf("u%0d data", k), dv[k], e.data);
                  check($sformatf("u%0d frame_err", k), fe[k], e.fe);
                  check($sformatf("u%0d parity_err", k), pe[k], e.pe);
               end
            end
            p[k] = rda[k];
         end
      end
   endtask

   initial begin
      fork
         monitor();
      join_none
      hold(3);
      for (int k = 0; k < 3; k++)
         check($sformatf("u%0d reset outputs", k), {dv[k], rda[k], fe[k], pe[k], ov[k]}, 0);
      rst = 0;
      hold(40);
      push(0, 9'hA5, 0, 0);
      send(0, 9'hA5, 8, 16, -1, 1);
      drain(0);
      rd_word(0);
      push(1, 9'h03, 0, 1);
      send(1, 9'h03, 8, 16, 1, 1);
      drain(1);
      rd_word(1);
      push(1, 9'h03, 0, 0);
      send(1, 9'h03, 8, 16, 0, 1);
      drain(1);
      rd_word(1);
      rx[0] = 1'b0;
      hold(8);
      rx[0] = 1'b1;
      hold(80);
      check("u0 RDA after glitch", rda[0], 0);
      push(0, 9'h11, 0, 0);
      send(0, 9'h11, 8, 16, -1, 1);
      send(0, 9'h22, 8, 16, -1, 1);
      drain(0);
      check("u0 held data on overrun", dv[0], 9'h11);
      check("u0 RDA on overrun", rda[0], 1);
      check("u0 overrun set", ov[0], 1);
      rd_word(0);
      check("u0 overrun cleared", ov[0], 0);
      push(0, 9'h5A, 1, 0);
      send(0, 9'h5A, 8, 16, -1, 0);
      drain(0);
      rd_word(0);
      push(0, 9'h3C, 0, 0);
      send(0, 9'h3C, 8, 16, -1, 1);
      drain(0);
      rd_word(0);
      push(2, 9'h15, 0, 0);
      send(2, 9'h15, 5, 8, 0, 1);
      drain(2);
      rd_word(2);
      push(2, 9'h15, 0, 1);
      send(2, 9'h15, 5, 8, 1, 1);
      drain(2);
      rx[2] = 1'b0;
      hold(16);
      rx[2] = 1'b1;
      hold(16);
      rst = 1;
      hold(2);
      check("u2 outputs under mid-frame reset", {dv[2], rda[2], fe[2], pe[2], ov[2]}, 0);
      rst = 0;
      hold(32);
      push(2, 9'h0B, 0, 0);
      send(2, 9'h0B, 5, 8, 0, 1);
      drain(2);
      rd_word(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
